instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0000_0000, byte address assigned to the first word after reset.
REQ-002 clk_i  input  1  clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 valid_i  input  1  request valid.
REQ-005 ready_o  output  1  request accepted when valid_i && ready_o at a clock edge.
REQ-006 op_sel_i  input  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BEQ, 5 BNE, 6 LW, 7 SW, 8 ADDI, 9 SLTI, 10 SLTIU, 11 ANDI, 12 ORI, 13 SLLI, 14 SRAI, 15 illegal.
REQ-007 rd_i / rs1_i / rs2_i  input  5 each  register indices; fields unused by the op are ignored.
REQ-008 imm_i  input  32  signed immediate value; for LUI/AUIPC the full byte value, e.g. 0x12345000.
REQ-009 valid_o  output  1  encoded word available.
REQ-010 ready_i  input  1  word consumed when valid_o && ready_i at a clock edge.
REQ-011 instr_o  output  32  encoded RV32I instruction word.
REQ-012 addr_o  output  32  byte address bound to instr_o.
REQ-013 err_o  output  1  current word was substituted because of an encoding error.
REQ-014 sticky_err_o  output  1  set by any error since reset.

Function
REQ-015 Request path: on accept, the encoder SHALL form the word combinationally and push {word, addr, err} into a 2-entry FIFO in the same edge.
REQ-016 Standard RV32I field placement and opcodes SHALL be used.
  - U-type: LUI 0110111, AUIPC 0010111, word[31:12] = imm_i[31:12].
  - J-type: JAL 1101111, imm[20|10:1|11|19:12].
  - I-type: JALR 1100111 funct3 000; LW 0000011 funct3 010; ADDI/SLTI/SLTIU/ANDI/ORI 0010011 funct3 000/010/011/111/110.
  - S-type: SW 0100011 funct3 010.
  - B-type: BEQ/BNE 1100011 funct3 000/001, imm[12|10:5] and imm[4:1|11].
  - Shifts: SLLI funct3 001 funct7 0000000; SRAI funct3 101 funct7 0100000; shamt in [24:20].
REQ-017 Range checks SHALL be applied; any violation is an error.
  - I/S: imm_i in -2048..2047.
  - B: imm_i in -4096..4094 and even.
  - J: imm_i in -1048576..1048574 and even.
  - U: imm_i[11:0] == 0.
  - Shifts: imm_i in 0..31.
  - op_sel_i == 15: always an error.
REQ-018 On error, the pushed word SHALL be 32'h0000_0013 (NOP) with err = 1; sticky_err_o SHALL go to 1 on the following edge.
REQ-019 Address counter:
  - resets to BASE_ADDR;
  - increments by 4 on each push, including error pushes;
  - wraps modulo 2^32 from 0xFFFF_FFFC to 0.
REQ-020 FIFO depth 2, in order.
  - ready_o = !full.
  - valid_o = !empty.
  - instr_o/addr_o/err_o show the head entry.
REQ-021 Latency: a word pushed into an empty FIFO at edge N SHALL show valid_o = 1 after edge N.
REQ-022 Simultaneous push and pop with one entry held: the count stays 1, the head advances to the new word, and no bubble is inserted.
REQ-023 Simultaneous push and pop when full: no push occurs because ready_o = 0, and the pop frees one entry.
REQ-024 Pop when empty, or push when full: no effect, and no state change.
REQ-025 Outputs SHALL remain stable while valid_o && !ready_i.
REQ-026 ready_o SHALL depend only on registered state, with no combinational path from valid_i or ready_i.

Reset
REQ-027 While rst_i = 1 at an edge, the next state SHALL be:
  - FIFO empty, so valid_o = 0 and ready_o = 1;
  - instr_o = 0, addr_o = BASE_ADDR, err_o = 0;
  - sticky_err_o = 0, address counter = BASE_ADDR.
REQ-028 Reset asserted mid-stream SHALL discard all buffered words, ignore any handshake at that edge, and restart addressing at BASE_ADDR.

Verification
REQ-029 ADDI rd=1, rs1=0, imm=5 with ready_i=1 -> next cycle valid_o=1, instr_o=0x00500093, addr_o=0x0, err_o=0.
REQ-030 SW rs2=2, rs1=1, imm=-4, then JAL rd=1, imm=8, back-to-back -> instr_o 0xFE20AE23 @0x0 then 0x008000EF @0x4, one word per cycle.
REQ-031 LUI rd=5, imm=0x12345000 -> 0x123452B7. LUI imm=0x12345001 -> 0x00000013 with err_o=1, and sticky_err_o=1 thereafter.
REQ-032 ready_i=0, three consecutive valid_i requests -> two accepted (addrs 0x0, 0x4), then ready_o=0. Raise ready_i -> the third is accepted as soon as one entry pops.
REQ-033 BASE_ADDR=0xFFFF_FFFC, two pushes -> addr_o 0xFFFF_FFFC then 0x0.
REQ-034 Two words buffered and sticky_err_o=1, then pulse rst_i -> valid_o=0, ready_o=1, sticky_err_o=0; the next push gets addr_o = BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_if
//   Groups the request/response handshake and data signals of instr_encoder.
//   The encoder connects through the slave modport, and its driver (a core or
//   testbench) connects through the master modport.
//
//   Request side  : valid_i, ready_o, op_sel_i, rd_i, rs1_i, rs2_i, imm_i
//   Response side : valid_o, ready_i, instr_o, addr_o, err_o
//   Status        : sticky_err_o
// ----------------------------------------------------------------------------
interface instr_encoder_if;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  op_sel_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [31:0] imm_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic        sticky_err_o;

  modport slave (
    input  valid_i, op_sel_i, rd_i, rs1_i, rs2_i, imm_i, ready_i,
    output ready_o, valid_o, instr_o, addr_o, err_o, sticky_err_o
  );

  modport master (
    output valid_i, op_sel_i, rd_i, rs1_i, rs2_i, imm_i, ready_i,
    input  ready_o, valid_o, instr_o, addr_o, err_o, sticky_err_o
  );
endinterface

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//   Turns an operation selector plus register indices and an immediate into
//   an RV32I instruction word. Every accepted request is tagged with a
//   running byte address and pushed into a two-entry in-order output FIFO.
//   Requests whose immediate cannot be encoded, and the illegal selector,
//   are replaced by a NOP with the error flag set.
//
//   Parameters
//     BASE_ADDR    byte address given to the first word after reset
//   Ports
//     clk_i        clock, rising edge
//     rst_i        synchronous active-high reset
//     bus          instr_encoder_if.slave (request in, encoded word out)
// ----------------------------------------------------------------------------
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  instr_encoder_if.slave  bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  logic [31:0]        imm;
  logic signed [31:0] imm_s;
  logic [4:0]         rd;
  logic [4:0]         rs1;
  logic [4:0]         rs2;

  logic i_ok;
  logic b_ok;
  logic j_ok;
  logic u_ok;
  logic sh_ok;

  logic [31:0] enc_word;
  logic        enc_ok;

  entry_t      head_q;
  entry_t      tail_q;
  logic [1:0]  count_q;
  logic [31:0] addr_cnt_q;
  logic        sticky_q;

  logic   push;
  logic   pop;
  entry_t new_entry;

  assign imm   = bus.imm_i;
  assign imm_s = bus.imm_i;
  assign rd    = bus.rd_i;
  assign rs1   = bus.rs1_i;
  assign rs2   = bus.rs2_i;

  // Immediate range checks per encoding format. Branch and jump offsets
  // must also be even because bit 0 is not stored in the word.
  assign i_ok  = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign b_ok  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
  assign j_ok  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];
  assign u_ok  = (imm[11:0] == 12'd0);
  assign sh_ok = (imm <= 32'd31);

  // Field packing for each operation. enc_ok carries the legality of the
  // immediate; the illegal selector falls through with enc_ok = 0.
  always_comb begin
    enc_word = NOP;
    enc_ok   = 1'b0;
    case (bus.op_sel_i)
      4'd0:  begin enc_ok = u_ok; enc_word = {imm[31:12], rd, 7'b0110111}; end
      4'd1:  begin enc_ok = u_ok; enc_word = {imm[31:12], rd, 7'b0010111}; end
      4'd2:  begin
        enc_ok   = j_ok;
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      end
      4'd3:  begin enc_ok = i_ok; enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111}; end
      4'd4:  begin
        enc_ok   = b_ok;
        enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      end
      4'd5:  begin
        enc_ok   = b_ok;
        enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
      end
      4'd6:  begin enc_ok = i_ok; enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011}; end
      4'd7:  begin
        enc_ok   = i_ok;
        enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      end
      4'd8:  begin enc_ok = i_ok; enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b0010011}; end
      4'd9:  begin enc_ok = i_ok; enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0010011}; end
      4'd10: begin enc_ok = i_ok; enc_word = {imm[11:0], rs1, 3'b011, rd, 7'b0010011}; end
      4'd11: begin enc_ok = i_ok; enc_word = {imm[11:0], rs1, 3'b111, rd, 7'b0010011}; end
      4'd12: begin enc_ok = i_ok; enc_word = {imm[11:0], rs1, 3'b110, rd, 7'b0010011}; end
      4'd13: begin
        enc_ok   = sh_ok;
        enc_word = {7'b0000000, imm[4:0], rs1, 3'b001, rd, 7'b0010011};
      end
      4'd14: begin
        enc_ok   = sh_ok;
        enc_word = {7'b0100000, imm[4:0], rs1, 3'b101, rd, 7'b0010011};
      end
      default: begin
        enc_ok   = 1'b0;
        enc_word = NOP;
      end
    endcase
  end

  // Handshakes. ready_o comes only from the registered occupancy, so there
  // is no combinational path from valid_i or ready_i to it.
  assign push = bus.valid_i && (count_q != 2'd2);
  assign pop  = bus.ready_i && (count_q != 2'd0);

  assign new_entry.word = enc_ok ? enc_word : NOP;
  assign new_entry.addr = addr_cnt_q;
  assign new_entry.err  = !enc_ok;

  // FIFO, address counter and sticky error. head_q is always the oldest
  // entry, so the outputs come straight from registers and stay stable
  // while the consumer stalls. A push together with a pop can only happen
  // with exactly one entry held, where the new word replaces the head
  // without a bubble. When full, no push is possible and a pop moves the
  // second entry forward.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q     <= '{word: 32'd0, addr: BASE_ADDR, err: 1'b0};
      tail_q     <= '{word: 32'd0, addr: BASE_ADDR, err: 1'b0};
      count_q    <= 2'd0;
      addr_cnt_q <= BASE_ADDR;
      sticky_q   <= 1'b0;
    end else begin
      if (push) begin
        addr_cnt_q <= addr_cnt_q + 32'd4;
        if (new_entry.err) begin
          sticky_q <= 1'b1;
        end
      end
      if (push && pop) begin
        head_q <= new_entry;
      end else if (push) begin
        if (count_q == 2'd0) begin
          head_q <= new_entry;
        end else begin
          tail_q <= new_entry;
        end
        count_q <= count_q + 2'd1;
      end else if (pop) begin
        if (count_q == 2'd2) begin
          head_q <= tail_q;
        end
        count_q <= count_q - 2'd1;
      end
    end
  end

  assign bus.ready_o      = (count_q != 2'd2);
  assign bus.valid_o      = (count_q != 2'd0);
  assign bus.instr_o      = head_q.word;
  assign bus.addr_o       = head_q.addr;
  assign bus.err_o        = head_q.err;
  assign bus.sticky_err_o = sticky_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
//   Self-checking bench for instr_encoder: a table of hand-encoded vectors,
//   a few multi-cycle handshake and reset sequences, a wrap-around instance
//   with BASE_ADDR = 0xFFFF_FFFC, and a randomized run checked against a
//   behavioural model built from plain integer arithmetic and a queue.
// ----------------------------------------------------------------------------
module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  instr_encoder_if bus0 ();
  instr_encoder_if bus1 ();

  instr_encoder #(.BASE_ADDR(32'h0000_0000)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0.slave)
  );

  instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int          op;
    int          rd;
    int          rs1;
    int          rs2;
    int          imm;
    logic [31:0] exp_word;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
    bit          err;
  } exp_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input int op, input int rd, input int rs1, input int rs2,
                                input int imm, input bit valid, input bit rdy);
    bus0.op_sel_i = 4'(op);
    bus0.rd_i     = 5'(rd);
    bus0.rs1_i    = 5'(rs1);
    bus0.rs2_i    = 5'(rs2);
    bus0.imm_i    = 32'(imm);
    bus0.valid_i  = valid;
    bus0.ready_i  = rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference encoder: legality from integer ranges, word from field values
  // weighted by their bit positions.
  function automatic void ref_encode(input int op, input int rd, input int rs1, input int rs2,
                                     input int imm, output logic [31:0] w, output bit err);
    int unsigned u;
    int unsigned f3;
    int unsigned opc;
    bit ok;
    u   = imm;
    ok  = 1'b0;
    w   = 32'h13;
    f3  = 0;
    opc = 'h13;
    case (op)
      0, 1: begin
        ok = (u % 4096) == 0;
        w  = (u / 4096) * 4096 + rd * 128 + ((op == 0) ? 'h37 : 'h17);
      end
      2: begin
        ok = (imm >= -1048576) && (imm <= 1048574) && (imm % 2 == 0);
        w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) |
             (((u >> 11) & 1) << 20) | (((u >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
      end
      3, 6, 8, 9, 10, 11, 12: begin
        ok = (imm >= -2048) && (imm <= 2047);
        case (op)
          3:  begin f3 = 0; opc = 'h67; end
          6:  begin f3 = 2; opc = 'h03; end
          8:  f3 = 0;
          9:  f3 = 2;
          10: f3 = 3;
          11: f3 = 7;
          default: f3 = 6;
        endcase
        w = ((u % 4096) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
      end
      7: begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = (((u >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) |
             ((u & 'h1F) << 7) | 'h23;
      end
      4, 5: begin
        ok = (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
        w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (rs2 << 20) |
             (rs1 << 15) | ((op - 4) << 12) | (((u >> 1) & 'hF) << 8) |
             (((u >> 11) & 1) << 7) | 'h63;
      end
      13, 14: begin
        ok = (imm >= 0) && (imm <= 31);
        w  = ((op == 14) ? 32'h4000_0000 : 32'h0) | (u << 20) | (rs1 << 15) |
             (((op == 14) ? 5 : 1) << 12) | (rd << 7) | 'h13;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) w = 32'h13;
    err = !ok;
  endfunction

  function automatic int gen_imm();
    int bnd[12] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095,
                    -1048576, 1048574, 1048576, 32};
    case ($urandom_range(0, 4))
      0: return int'($urandom_range(0, 64)) - 16;
      1: return int'($urandom_range(0, 8191)) - 4096;
      2: return bnd[$urandom_range(0, 11)];
      3: return int'($urandom & 32'hFFFF_F000);
      default: return int'($urandom);
    endcase
  endfunction

  initial begin
    exp_t        q[$];
    logic [31:0] exp_addr;
    bit          exp_sticky;
    logic [31:0] w;
    bit          e;

    apply_stimulus(0, 0, 0, 0, 0, 1'b0, 1'b0);
    bus1.valid_i = 1'b0; bus1.ready_i = 1'b0; bus1.op_sel_i = 4'd8;
    bus1.rd_i = 5'd0; bus1.rs1_i = 5'd0; bus1.rs2_i = 5'd0; bus1.imm_i = 32'd0;

    // ---------------- reset state ----------------
    do_reset();
    check_output("reset valid_o", 32'(bus0.valid_o), 32'd0);
    check_output("reset ready_o", 32'(bus0.ready_o), 32'd1);
    check_output("reset instr_o", bus0.instr_o, 32'd0);
    check_output("reset addr_o", bus0.addr_o, 32'd0);
    check_output("reset err_o", 32'(bus0.err_o), 32'd0);
    check_output("reset sticky", 32'(bus0.sticky_err_o), 32'd0);

    // ---------------- table-driven vectors ----------------
    vecs.push_back('{8, 1, 0, 0, 5, 32'h0050_0093, 1'b0});
    vecs.push_back('{7, 0, 1, 2, -4, 32'hFE20_AE23, 1'b0});
    vecs.push_back('{2, 1, 0, 0, 8, 32'h0080_00EF, 1'b0});
    vecs.push_back('{0, 5, 0, 0, 32'h1234_5000, 32'h1234_52B7, 1'b0});
    vecs.push_back('{0, 5, 0, 0, 32'h1234_5001, 32'h0000_0013, 1'b1});
    vecs.push_back('{15, 1, 1, 1, 0, 32'h0000_0013, 1'b1});
    vecs.push_back('{8, 1, 1, 0, 2048, 32'h0000_0013, 1'b1});
    vecs.push_back('{8, 1, 1, 0, -2048, 32'h8000_8093, 1'b0});
    vecs.push_back('{4, 0, 1, 2, 3, 32'h0000_0013, 1'b1});
    vecs.push_back('{5, 0, 1, 2, -4096, 32'h8020_9063, 1'b0});
    vecs.push_back('{14, 3, 4, 0, 7, 32'h4072_5193, 1'b0});
    vecs.push_back('{13, 3, 4, 0, 32, 32'h0000_0013, 1'b1});
    vecs.push_back('{1, 1, 0, 0, -4096, 32'hFFFF_F097, 1'b0});
    vecs.push_back('{6, 2, 3, 0, 8, 32'h0081_A103, 1'b0});
    vecs.push_back('{3, 0, 1, 0, 0, 32'h0000_8067, 1'b0});
    vecs.push_back('{10, 1, 2, 0, -1, 32'hFFF1_3093, 1'b0});
    vecs.push_back('{2, 1, 0, 0, 1048576, 32'h0000_0013, 1'b1});

    exp_sticky = 1'b0;
    foreach (vecs[i]) begin
      @(negedge clk);
      apply_stimulus(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      exp_sticky = exp_sticky | vecs[i].exp_err;
      check_output($sformatf("vec%0d valid_o", i), 32'(bus0.valid_o), 32'd1);
      check_output($sformatf("vec%0d instr_o", i), bus0.instr_o, vecs[i].exp_word);
      check_output($sformatf("vec%0d err_o", i), 32'(bus0.err_o), 32'(vecs[i].exp_err));
      check_output($sformatf("vec%0d addr_o", i), bus0.addr_o, 32'(4 * i));
      check_output($sformatf("vec%0d sticky", i), 32'(bus0.sticky_err_o), 32'(exp_sticky));
    end
    @(negedge clk);
    apply_stimulus(8, 0, 0, 0, 0, 1'b0, 1'b1);

    // ---------------- backpressure: three requests, consumer stalled ----------------
    do_reset();
    apply_stimulus(8, 1, 0, 0, 1, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_output("bp first ready_o", 32'(bus0.ready_o), 32'd1);
    @(negedge clk);
    apply_stimulus(8, 1, 0, 0, 2, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_output("bp full ready_o", 32'(bus0.ready_o), 32'd0);
    check_output("bp head addr", bus0.addr_o, 32'h0);
    check_output("bp head instr", bus0.instr_o, 32'h0010_0093);
    @(negedge clk);
    apply_stimulus(8, 1, 0, 0, 3, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_output("bp stall instr", bus0.instr_o, 32'h0010_0093);
    check_output("bp stall ready_o", 32'(bus0.ready_o), 32'd0);
    @(negedge clk);
    bus0.ready_i = 1'b1;
    @(posedge clk); #1;
    check_output("bp pop addr", bus0.addr_o, 32'h4);
    check_output("bp pop ready_o", 32'(bus0.ready_o), 32'd1);
    @(posedge clk); #1;
    check_output("bp third addr", bus0.addr_o, 32'h8);
    check_output("bp third instr", bus0.instr_o, 32'h0030_0093);
    @(negedge clk);
    bus0.valid_i = 1'b0;

    // ---------------- reset mid-stream with buffered words ----------------
    do_reset();
    apply_stimulus(15, 0, 0, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    apply_stimulus(8, 1, 0, 0, 5, 1'b1, 1'b0);
    @(negedge clk);
    check_output("mid sticky before", 32'(bus0.sticky_err_o), 32'd1);
    check_output("mid full", 32'(bus0.ready_o), 32'd0);
    rst = 1'b1;
    apply_stimulus(8, 1, 0, 0, 5, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    bus0.valid_i = 1'b0;
    check_output("mid valid_o", 32'(bus0.valid_o), 32'd0);
    check_output("mid ready_o", 32'(bus0.ready_o), 32'd1);
    check_output("mid sticky", 32'(bus0.sticky_err_o), 32'd0);
    check_output("mid addr_o", bus0.addr_o, 32'h0);
    apply_stimulus(8, 1, 0, 0, 5, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_output("mid next addr", bus0.addr_o, 32'h0);
    check_output("mid next instr", bus0.instr_o, 32'h0050_0093);
    @(negedge clk);
    bus0.valid_i = 1'b0;

    // ---------------- address wrap on the second instance ----------------
    do_reset();
    bus1.valid_i = 1'b1; bus1.ready_i = 1'b1; bus1.rd_i = 5'd1; bus1.imm_i = 32'd5;
    @(posedge clk); #1;
    check_output("wrap first addr", bus1.addr_o, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check_output("wrap second addr", bus1.addr_o, 32'h0);
    check_output("wrap valid_o", 32'(bus1.valid_o), 32'd1);
    @(negedge clk);
    bus1.valid_i = 1'b0;

    // ---------------- randomized run against the model ----------------
    do_reset();
    exp_addr   = 32'h0;
    exp_sticky = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit rst_now;
      bit v;
      bit r;
      int op;
      int rd;
      int rs1;
      int rs2;
      int imm;
      @(negedge clk);
      rst = 1'b0;
      check_output("rnd valid_o", 32'(bus0.valid_o), 32'(q.size() != 0));
      check_output("rnd ready_o", 32'(bus0.ready_o), 32'(q.size() < 2));
      check_output("rnd sticky", 32'(bus0.sticky_err_o), 32'(exp_sticky));
      if (q.size() != 0) begin
        check_output("rnd instr_o", bus0.instr_o, q[0].word);
        check_output("rnd addr_o", bus0.addr_o, q[0].addr);
        check_output("rnd err_o", 32'(bus0.err_o), 32'(q[0].err));
      end
      rst_now = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 2) != 0);
      op  = int'($urandom_range(0, 15));
      rd  = int'($urandom_range(0, 31));
      rs1 = int'($urandom_range(0, 31));
      rs2 = int'($urandom_range(0, 31));
      imm = gen_imm();
      rst = rst_now;
      apply_stimulus(op, rd, rs1, rs2, imm, v, r);
      @(posedge clk);
      if (rst_now) begin
        q.delete();
        exp_addr   = 32'h0;
        exp_sticky = 1'b0;
      end else begin
        bit do_push;
        do_push = v && (q.size() < 2);
        if (r && q.size() != 0) void'(q.pop_front());
        if (do_push) begin
          ref_encode(op, rd, rs1, rs2, imm, w, e);
          q.push_back('{w, exp_addr, e});
          exp_addr   = exp_addr + 32'd4;
          exp_sticky = exp_sticky | e;
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus0.valid_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
